excp_commit: RTL and testbench

- WB-stage exception/ERTN commit unit and owner of the exception CSRs: CRMD, PRMD, ESTAT, ERA, EENTRY and optionally BADV.
- Decides whether the instruction in WB raises an exception or executes ERTN, and drives is_exception, exception_cause, is_ertn, EENTRY_VA and ERA_PC into the pipeline controller.
- Updates the CSR state at commit.
- Squashes younger instructions that reach WB during a fixed post-redirect shadow.

---
 rtl/excp_commit.sv | 176 +++++++++++++++++
 tb/tb_excp_commit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/excp_commit.sv
// WB-stage exception/ERTN commit unit owning CRMD, PRMD, ESTAT, ERA, EENTRY.
// Optional BADV register enabled by defining EXCP_BADV_EN.
module excp_commit #(
    parameter int FLUSH_CYCLES = 3,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_pc,
    input  logic              wb_excp,
    input  logic [5:0]        wb_ecode,
    input  logic [8:0]        wb_esubcode,
    input  logic              wb_is_ertn,
    input  logic [ADDR_W-1:0] wb_badv,
    input  logic              wb_csr_write_en_i,
    input  logic [13:0]       wb_csr_write_addr_i,
    input  logic [ADDR_W-1:0] wb_csr_write_data_i,
    input  logic [13:0]       csr_read_addr,
    output logic [ADDR_W-1:0] csr_read_data,
    output logic              is_exception,
    output logic [14:0]       exception_cause,
    output logic              is_ertn,
    output logic [ADDR_W-1:0] EENTRY_VA,
    output logic [ADDR_W-1:0] ERA_PC,
    output logic [1:0]        cur_plv,
    output logic              cur_ie
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SHADOW = 1'b1;

    localparam logic [13:0] A_CRMD   = 14'h0;
    localparam logic [13:0] A_PRMD   = 14'h1;
    localparam logic [13:0] A_ESTAT  = 14'h5;
    localparam logic [13:0] A_ERA    = 14'h6;
    localparam logic [13:0] A_BADV   = 14'h7;
    localparam logic [13:0] A_EENTRY = 14'hC;

    logic [0:0]        state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [1:0]        plv, plv_n, pplv, pplv_n, is_bits, is_bits_n;
    logic              ie, ie_n, pie, pie_n;
    logic [5:0]        ecode, ecode_n;
    logic [8:0]        esub, esub_n;
    logic [ADDR_W-1:0] era, era_n;
    logic [ADDR_W-7:0] eentry, eentry_n;
    logic [ADDR_W-1:0] rd_n;
    logic              commit, csr_we;

`ifdef EXCP_BADV_EN
    logic [ADDR_W-1:0] badv, badv_n;
`else
    logic unused_badv;
    assign unused_badv = ^wb_badv;
`endif

    assign commit          = !rst && (state == IDLE) && wb_valid;
    assign is_exception    = commit && wb_excp;
    assign is_ertn         = commit && !wb_excp && wb_is_ertn;
    assign csr_we          = commit && !wb_excp && !wb_is_ertn && wb_csr_write_en_i;
    assign exception_cause = is_exception ? {wb_esubcode, wb_ecode} : 15'd0;

    assign EENTRY_VA = {eentry, 6'b0};
    assign ERA_PC    = era;
    assign cur_plv   = plv;
    assign cur_ie    = ie;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        plv_n     = plv;
        ie_n      = ie;
        pplv_n    = pplv;
        pie_n     = pie;
        is_bits_n = is_bits;
        ecode_n   = ecode;
        esub_n    = esub;
        era_n     = era;
        eentry_n  = eentry;
`ifdef EXCP_BADV_EN
        badv_n    = badv;
`endif
        if (state == SHADOW) begin
            cnt_n = cnt - 4'd1;
            if (cnt == 4'd1) state_n = IDLE;
        end else if (is_exception) begin
            pplv_n  = plv;
            pie_n   = ie;
            plv_n   = 2'd0;
            ie_n    = 1'b0;
            era_n   = wb_pc;
            ecode_n = wb_ecode;
            esub_n  = wb_esubcode;
`ifdef EXCP_BADV_EN
            if (wb_ecode == 6'h08 || wb_ecode == 6'h09) badv_n = wb_badv;
`endif
            state_n = SHADOW;
            cnt_n   = 4'(FLUSH_CYCLES);
        end else if (is_ertn) begin
            plv_n   = pplv;
            ie_n    = pie;
            state_n = SHADOW;
            cnt_n   = 4'(FLUSH_CYCLES);
        end else if (csr_we) begin
            case (wb_csr_write_addr_i)
                A_CRMD:   {ie_n, plv_n}  = wb_csr_write_data_i[2:0];
                A_PRMD:   {pie_n, pplv_n} = wb_csr_write_data_i[2:0];
                A_ESTAT:  is_bits_n      = wb_csr_write_data_i[1:0];
                A_ERA:    era_n          = wb_csr_write_data_i;
`ifdef EXCP_BADV_EN
                A_BADV:   badv_n         = wb_csr_write_data_i;
`endif
                A_EENTRY: eentry_n       = wb_csr_write_data_i[ADDR_W-1:6];
                default:  ;
            endcase
        end
    end

    // Read mux sees post-update values so the registered result is current.
    always_comb begin
        rd_n = '0;
        case (csr_read_addr)
            A_CRMD:   rd_n[3:0] = {1'b1, ie_n, plv_n};
            A_PRMD:   rd_n[2:0] = {pie_n, pplv_n};
            A_ESTAT: begin
                rd_n[1:0]   = is_bits_n;
                rd_n[21:16] = ecode_n;
                rd_n[30:22] = esub_n;
            end
            A_ERA:    rd_n = era_n;
`ifdef EXCP_BADV_EN
            A_BADV:   rd_n = badv_n;
`endif
            A_EENTRY: rd_n = {eentry_n, 6'b0};
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            plv           <= 2'd0;
            ie            <= 1'b0;
            pplv          <= 2'd0;
            pie           <= 1'b0;
            is_bits       <= 2'd0;
            ecode         <= 6'd0;
            esub          <= 9'd0;
            era           <= '0;
            eentry        <= '0;
            csr_read_data <= '0;
`ifdef EXCP_BADV_EN
            badv          <= '0;
`endif
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            plv           <= plv_n;
            ie            <= ie_n;
            pplv          <= pplv_n;
            pie           <= pie_n;
            is_bits       <= is_bits_n;
            ecode         <= ecode_n;
            esub          <= esub_n;
            era           <= era_n;
            eentry        <= eentry_n;
            csr_read_data <= rd_n;
`ifdef EXCP_BADV_EN
            badv          <= badv_n;
`endif
        end
    end

endmodule

// File: tb/tb_excp_commit.sv
// Bench for excp_commit: CSR-array reference model checked every cycle,
// plus directed literal expectations.
module tb_excp_commit;

    localparam int AW = 32;
    localparam int FL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid, wb_excp, wb_is_ertn, wb_csr_write_en_i;
    logic [AW-1:0] wb_pc, wb_badv, wb_csr_write_data_i;
    logic [5:0]    wb_ecode;
    logic [8:0]    wb_esubcode;
    logic [13:0]   wb_csr_write_addr_i, csr_read_addr;
    logic [AW-1:0] csr_read_data, EENTRY_VA, ERA_PC;
    logic          is_exception, is_ertn, cur_ie;
    logic [14:0]   exception_cause;
    logic [1:0]    cur_plv;

    excp_commit #(.FLUSH_CYCLES(FL), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_excp(wb_excp),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_is_ertn(wb_is_ertn), .wb_badv(wb_badv),
        .wb_csr_write_en_i(wb_csr_write_en_i),
        .wb_csr_write_addr_i(wb_csr_write_addr_i),
        .wb_csr_write_data_i(wb_csr_write_data_i),
        .csr_read_addr(csr_read_addr), .csr_read_data(csr_read_data),
        .is_exception(is_exception), .exception_cause(exception_cause),
        .is_ertn(is_ertn), .EENTRY_VA(EENTRY_VA), .ERA_PC(ERA_PC),
        .cur_plv(cur_plv), .cur_ie(cur_ie)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural CSR images and remaining squash count.
    logic [31:0] m_csr [16];
    int          m_sq = 0;
    logic [31:0] m_rd = 0;

    function automatic bit impl(input logic [13:0] a);
`ifdef EXCP_BADV_EN
        return a == 0 || a == 1 || a == 5 || a == 6 || a == 7 || a == 12;
`else
        return a == 0 || a == 1 || a == 5 || a == 6 || a == 12;
`endif
    endfunction

    function automatic logic [31:0] wmask(input logic [13:0] a);
        case (a)
            14'd0, 14'd1: return 32'h7;
            14'd5:        return 32'h3;
            14'd12:       return 32'hFFFF_FFC0;
            default:      return 32'hFFFF_FFFF;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] nw [16];
        int sq;
        nw = m_csr;
        sq = m_sq;
        if (rst) begin
            foreach (nw[i]) nw[i] = 32'h0;
            nw[0] = 32'h8;
            sq = 0;
            m_rd <= 32'h0;
        end else begin
            if (sq > 0) begin
                sq--;
            end else if (wb_valid && wb_excp) begin
                nw[1] = {29'b0, m_csr[0][2:0]};
                nw[0] = 32'h8;
                nw[6] = wb_pc;
                nw[5] = {1'b0, wb_esubcode, wb_ecode, 14'b0, m_csr[5][1:0]};
`ifdef EXCP_BADV_EN
                if (wb_ecode == 6'h08 || wb_ecode == 6'h09) nw[7] = wb_badv;
`endif
                sq = FL;
            end else if (wb_valid && wb_is_ertn) begin
                nw[0] = 32'h8 | {29'b0, m_csr[1][2:0]};
                sq = FL;
            end else if (wb_valid && wb_csr_write_en_i && impl(wb_csr_write_addr_i)) begin
                nw[wb_csr_write_addr_i[3:0]] =
                    (m_csr[wb_csr_write_addr_i[3:0]] & ~wmask(wb_csr_write_addr_i))
                    | (wb_csr_write_data_i & wmask(wb_csr_write_addr_i));
            end
            m_rd <= impl(csr_read_addr) ? nw[csr_read_addr[3:0]] : 32'h0;
        end
        m_csr <= nw;
        m_sq  <= sq;
    end

    always @(negedge clk) begin : compare
        logic ex, er;
        ex = !rst && m_sq == 0 && wb_valid && wb_excp;
        er = !rst && m_sq == 0 && wb_valid && !wb_excp && wb_is_ertn;
        chk("is_exception", 32'(is_exception), 32'(ex));
        chk("is_ertn", 32'(is_ertn), 32'(er));
        chk("exception_cause", 32'(exception_cause),
            ex ? 32'({wb_esubcode, wb_ecode}) : 32'h0);
        chk("EENTRY_VA", EENTRY_VA, m_csr[12]);
        chk("ERA_PC", ERA_PC, m_csr[6]);
        chk("cur_plv", 32'(cur_plv), 32'(m_csr[0][1:0]));
        chk("cur_ie", 32'(cur_ie), 32'(m_csr[0][2]));
        chk("csr_read_data", csr_read_data, m_rd);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        wb_valid = 0; wb_excp = 0; wb_is_ertn = 0; wb_csr_write_en_i = 0;
        wb_ecode = 0; wb_esubcode = 0; wb_pc = 0; wb_badv = 0;
        wb_csr_write_addr_i = 0; wb_csr_write_data_i = 0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        cyc();
        wb_valid = 1; wb_csr_write_en_i = 1;
        wb_csr_write_addr_i = a; wb_csr_write_data_i = d;
    endtask

    task automatic excp(input logic [5:0] ec, input logic [31:0] pc);
        cyc();
        wb_valid = 1; wb_excp = 1; wb_ecode = ec; wb_pc = pc;
    endtask

    logic [31:0] badv_exp1, badv_exp2;

    initial begin
`ifdef EXCP_BADV_EN
        badv_exp1 = 32'hDEAD_BEEF;
        badv_exp2 = 32'h1234_5678;
`else
        badv_exp1 = 32'h0;
        badv_exp2 = 32'h0;
`endif
        rst = 1;
        csr_read_addr = 14'h0;
        wb_valid = 0; wb_excp = 0; wb_is_ertn = 0; wb_csr_write_en_i = 0;
        wb_ecode = 0; wb_esubcode = 0; wb_pc = 0; wb_badv = 0;
        wb_csr_write_addr_i = 0; wb_csr_write_data_i = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        cyc(); #1;
        chk("reset_crmd", csr_read_data, 32'h8);
        chk("reset_eentry", EENTRY_VA, 32'h0);
        chk("reset_era", ERA_PC, 32'h0);
        chk("reset_excp", 32'(is_exception), 32'h0);

        wr(14'h0, 32'h7);
        wr(14'hC, 32'h1C00_0047);
        excp(6'h0B, 32'h1C00_0100);
        csr_read_addr = 14'h1;
        #1;
        chk("excp_taken", 32'(is_exception), 32'h1);
        chk("excp_cause", 32'(exception_cause), 32'h000B);

        for (int i = 0; i < FL; i++) begin
            cyc();
            if (i == 0) begin
                #1;
                chk("era_after", ERA_PC, 32'h1C00_0100);
                chk("eentry_after", EENTRY_VA, 32'h1C00_0040);
                chk("prmd_after", csr_read_data, 32'h7);
                chk("plv_after", 32'(cur_plv), 32'h0);
                chk("ie_after", 32'(cur_ie), 32'h0);
            end
            wb_valid = 1; wb_csr_write_en_i = 1;
            wb_csr_write_addr_i = 14'h6; wb_csr_write_data_i = 32'h1234_5678;
            wb_excp = (i == 1); wb_ecode = 6'h0B;
            #1;
            chk("shadow_no_excp", 32'(is_exception), 32'h0);
        end
        excp(6'h0A, 32'h1C00_0200);
        #1;
        chk("b2b_excp", 32'(is_exception), 32'h1);
        chk("shadow_no_write", ERA_PC, 32'h1C00_0100);
        repeat (FL) cyc();

        wr(14'h1, 32'h7);
        cyc();
        wb_valid = 1; wb_is_ertn = 1;
        #1;
        chk("ertn_taken", 32'(is_ertn), 32'h1);
        cyc(); #1;
        chk("ertn_plv", 32'(cur_plv), 32'h3);
        chk("ertn_ie", 32'(cur_ie), 32'h1);
        chk("ertn_era", ERA_PC, 32'h1C00_0200);
        repeat (FL - 1) cyc();

        excp(6'h01, 32'h1C00_0300);
        wb_is_ertn = 1; wb_csr_write_en_i = 1;
        wb_csr_write_addr_i = 14'h6; wb_csr_write_data_i = 32'hAAAA_5555;
        #1;
        chk("both_excp", 32'(is_exception), 32'h1);
        chk("both_ertn", 32'(is_ertn), 32'h0);
        cyc(); #1;
        chk("both_era", ERA_PC, 32'h1C00_0300);
        repeat (FL - 1) cyc();

        excp(6'h09, 32'h1C00_0400);
        wb_badv = 32'hDEAD_BEEF;
        csr_read_addr = 14'h7;
        cyc(); #1;
        chk("badv_ale", csr_read_data, badv_exp1);
        csr_read_addr = 14'h5;
        cyc(); #1;
        chk("estat_cause", csr_read_data, 32'h0009_0000);
        cyc();

        wr(14'h5, 32'hFFFF_FFFF);
        wr(14'h0, 32'h0);
        wr(14'h7, 32'h1234_5678);
        cyc(); #1;
        chk("estat_is", csr_read_data, 32'h0009_0003);
        csr_read_addr = 14'h0;
        cyc(); #1;
        chk("crmd_da", csr_read_data, 32'h8);
        csr_read_addr = 14'h2;
        cyc(); #1;
        chk("unimpl_read", csr_read_data, 32'h0);
        csr_read_addr = 14'h7;
        cyc(); #1;
        chk("badv_write", csr_read_data, badv_exp2);

        excp(6'h03, 32'h1C00_0500);
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        wb_valid = 1; wb_excp = 1; wb_ecode = 6'h04; wb_pc = 32'h1C00_0600;
        #1;
        chk("post_reset_excp", 32'(is_exception), 32'h1);
        chk("post_reset_era", ERA_PC, 32'h0);
        cyc(); #1;
        chk("post_reset_era2", ERA_PC, 32'h1C00_0600);
        repeat (FL + 1) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
